packet_tx: RTL and testbench
============================

PACKET_TX -- requirements
Module: packet_tx

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, first byte of every transmitted frame.
REQ-002 Parameter MAX_LEN, default 16, largest payload length accepted.
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-low.
REQ-005 tx_packet_wr  input  1  one-cycle request to send the packet on tx_payload_len/tx_buf*.
REQ-006 tx_payload_len  input  8  payload byte count.
REQ-007 tx_buf0..tx_buf15  input  8 each  payload bytes; tx_buf0 is sent first.
REQ-008 tx_busy  output  1  high while a frame is held or being sent.
REQ-009 tx_overrun  output  1  one-cycle pulse when a request is dropped.
REQ-010 out_byte  output  8  serial byte toward the UART transmitter.
REQ-011 out_valid  output  1  out_byte is valid.
REQ-012 out_ready  input  1  sink accepts out_byte; a byte transfers on any cycle where out_valid and out_ready are both high.

Function
REQ-013 Frame byte order:
- SYNC_BYTE
- length
- payload[0..length-1]
- checksum = (length + sum of payload bytes) mod 256
REQ-014 States: IDLE, SYNC, LEN, DATA, CSUM; encoding 3 bits.
REQ-015 IDLE, tx_packet_wr=1, tx_payload_len<=MAX_LEN: at that edge, capture length and all 16 buffer bytes into internal registers; go to SYNC.
REQ-016 tx_busy and out_valid rise in the cycle after the capture edge, so tx_busy is already high in the cycle after tx_packet_wr.
REQ-017 IDLE, tx_packet_wr=1, tx_payload_len>MAX_LEN: nothing captured; tx_overrun pulses the next cycle; stay IDLE.
REQ-018 tx_packet_wr while not IDLE: request ignored; captured data unchanged; tx_overrun pulses the next cycle.
REQ-019 SYNC→LEN, LEN→DATA, DATA→CSUM advance only on a transfer.
REQ-020 Length 0: LEN goes directly to CSUM; checksum is 8'h00.
REQ-021 DATA uses a 4-bit index starting at 0, incremented per transfer; it leaves DATA after the transfer with index = length-1.
REQ-022 CSUM transfer → IDLE; out_valid and tx_busy fall in the next cycle.
REQ-023 A new tx_packet_wr is accepted in the first IDLE cycle after a frame.
REQ-024 While out_valid=1 and out_ready=0: out_byte and state hold stable; out_valid never drops before its transfer.
REQ-025 Checksum accumulator: 8-bit, wraps modulo 256.
- Loaded with length at the capture edge.
- Adds each payload byte on its transfer.
REQ-026 out_ready held high: one byte per cycle, frame length+3 cycles from SYNC to CSUM.
REQ-027 out_byte is 0 whenever out_valid=0.

Reset
REQ-028 rst=0 at an edge:
- state → IDLE
- tx_busy, out_valid, tx_overrun → 0
- out_byte, index, checksum, captured length/bytes → 0
REQ-029 Reset mid-frame abandons the frame with no further bytes; out_valid is 0 in the cycle after the reset edge.
REQ-030 tx_packet_wr in a reset cycle is ignored.

Structure
REQ-031 Shared package packet_pkg holds:
- SYNC_BYTE default
- MAX_LEN
- state encoding constants
- response code constants 8'h80, 8'h81, 8'h85
The executor and the receiver use the same package.
REQ-032 Single module; no sub-module. The capture register bank and checksum stay inline.

Verification
REQ-033 Zero length: tx_packet_wr, len=0, out_ready=1 → bytes A5,00,00; tx_busy high exactly 3 cycles starting the cycle after wr.
REQ-034 Single byte: len=1, buf0=81 → A5,01,81,82.
REQ-035 Version: len=3, buf=81,BA,CE → A5,03,81,BA,CE,0C (wraps).
REQ-036 Backpressure: len=1, buf0=85, out_ready low 4 cycles during the LEN byte → 01 held stable for 4 cycles; output A5,01,85,86.
REQ-037 Overrun and oversize:
- Second tx_packet_wr mid-frame → tx_overrun pulse; first frame intact.
- len=17 → tx_overrun pulse; no output.
REQ-038 Reset: rst low during DATA → out_valid=0 next cycle; then len=1, buf0=80 → clean A5,01,80,81.

Source files
------------

// File: rtl/packet_pkg.sv
// ---------------------------------------------------------------------------
// packet_pkg
// Shared definitions for the packet transmitter and its peer receiver:
// default framing constants, the 3-bit transmitter state encoding and the
// response code bytes exchanged between executor and receiver.
// ---------------------------------------------------------------------------
package packet_pkg;

    // Framing defaults
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         MAX_LEN_DEFAULT   = 16;
    localparam int         BUF_DEPTH         = 16;

    // Transmitter state encoding (3 bits)
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } tx_state_e;

    // Response codes shared with the receiver
    localparam logic [7:0] RSP_ACK     = 8'h80;
    localparam logic [7:0] RSP_NAK     = 8'h81;
    localparam logic [7:0] RSP_VERSION = 8'h85;

endpackage

// File: rtl/packet_tx.sv
// ---------------------------------------------------------------------------
// packet_tx
// Frames a captured payload as SYNC_BYTE, length, payload[0..len-1],
// checksum and streams it one byte per transfer toward a UART transmitter.
//
// Handshake: a byte transfers on every rising edge where out_valid and
// out_ready are both high. Once out_valid is raised it stays high, with
// out_byte stable, until that byte transfers; out_valid never depends on
// out_ready. out_byte is 0 whenever out_valid is 0.
//
// Ports
//   clk             sole clock, rising edge
//   rst             synchronous active-low reset
//   tx_packet_wr    one-cycle send request
//   tx_payload_len  payload byte count (accepted when <= MAX_LEN)
//   tx_buf0..15     payload bytes, tx_buf0 sent first
//   tx_busy         high while a frame is held or being sent
//   tx_overrun      one-cycle pulse when a request is dropped
//   out_byte        serial byte toward the UART transmitter
//   out_valid       out_byte is valid
//   out_ready       sink accepts out_byte
//   dbg_state_o     current FSM state, for observation
// ---------------------------------------------------------------------------
module packet_tx
    import packet_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         MAX_LEN   = MAX_LEN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_packet_wr,
    input  logic [7:0] tx_payload_len,
    input  logic [7:0] tx_buf0,
    input  logic [7:0] tx_buf1,
    input  logic [7:0] tx_buf2,
    input  logic [7:0] tx_buf3,
    input  logic [7:0] tx_buf4,
    input  logic [7:0] tx_buf5,
    input  logic [7:0] tx_buf6,
    input  logic [7:0] tx_buf7,
    input  logic [7:0] tx_buf8,
    input  logic [7:0] tx_buf9,
    input  logic [7:0] tx_buf10,
    input  logic [7:0] tx_buf11,
    input  logic [7:0] tx_buf12,
    input  logic [7:0] tx_buf13,
    input  logic [7:0] tx_buf14,
    input  logic [7:0] tx_buf15,
    output logic       tx_busy,
    output logic       tx_overrun,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] dbg_state_o
);

    tx_state_e  state_q, state_d;

    logic [7:0] buf_in [BUF_DEPTH];
    logic [7:0] buf_q  [BUF_DEPTH];
    logic [7:0] buf_d  [BUF_DEPTH];
    logic [7:0] len_q, len_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] csum_q, csum_d;
    logic       overrun_q, overrun_d;

    logic       xfer;
    logic       accept;
    logic       last_data;

    assign buf_in[0]  = tx_buf0;
    assign buf_in[1]  = tx_buf1;
    assign buf_in[2]  = tx_buf2;
    assign buf_in[3]  = tx_buf3;
    assign buf_in[4]  = tx_buf4;
    assign buf_in[5]  = tx_buf5;
    assign buf_in[6]  = tx_buf6;
    assign buf_in[7]  = tx_buf7;
    assign buf_in[8]  = tx_buf8;
    assign buf_in[9]  = tx_buf9;
    assign buf_in[10] = tx_buf10;
    assign buf_in[11] = tx_buf11;
    assign buf_in[12] = tx_buf12;
    assign buf_in[13] = tx_buf13;
    assign buf_in[14] = tx_buf14;
    assign buf_in[15] = tx_buf15;

    assign xfer   = out_valid & out_ready;
    assign accept = tx_packet_wr && (state_q == ST_IDLE) &&
                    (int'(tx_payload_len) <= MAX_LEN);
    // A length of 16 truncates to 0 in 4 bits, so len-1 lands on index 15.
    assign last_data = (idx_q == 4'(len_q - 8'd1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_SYNC;
            ST_SYNC: if (xfer)   state_d = ST_LEN;
            ST_LEN:  if (xfer)   state_d = (len_q == 8'd0) ? ST_CSUM : ST_DATA;
            ST_DATA: if (xfer && last_data) state_d = ST_CSUM;
            ST_CSUM: if (xfer)   state_d = ST_IDLE;
            default:             state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        tx_busy     = (state_q != ST_IDLE);
        out_valid   = (state_q != ST_IDLE);
        tx_overrun  = overrun_q;
        dbg_state_o = state_q;
        out_byte    = 8'h00;
        case (state_q)
            ST_SYNC: out_byte = SYNC_BYTE;
            ST_LEN:  out_byte = len_q;
            ST_DATA: out_byte = buf_q[idx_q];
            ST_CSUM: out_byte = csum_q;
            default: out_byte = 8'h00;
        endcase
    end

    // ---------------- Capture bank, index and checksum ----------------
    always_comb begin
        len_d     = len_q;
        buf_d     = buf_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        // Any request that is not taken (busy or oversize) is reported.
        overrun_d = tx_packet_wr && !accept;
        if (accept) begin
            len_d  = tx_payload_len;
            buf_d  = buf_in;
            idx_d  = 4'd0;
            // Checksum starts from the length byte, payload is added per transfer.
            csum_d = tx_payload_len;
        end else if ((state_q == ST_DATA) && xfer) begin
            idx_d  = idx_q + 4'd1;
            csum_d = csum_q + out_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            len_q     <= 8'h00;
            idx_q     <= 4'd0;
            csum_q    <= 8'h00;
            overrun_q <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else begin
            len_q     <= len_d;
            buf_q     <= buf_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_packet_tx.sv
// ---------------------------------------------------------------------------
// tb_packet_tx
// Self-checking bench for packet_tx: directed table of frames with known
// checksums, hand-written multi-cycle sequences (backpressure, overrun,
// oversize, reset mid-frame) and randomized frames against a reference model.
// ---------------------------------------------------------------------------
module tb_packet_tx;
    import packet_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_packet_wr = 1'b0;
    logic [7:0] tx_payload_len = 8'h00;
    logic [7:0] buf_arr [16];
    logic       tx_busy, tx_overrun, out_valid;
    logic [7:0] out_byte;
    logic       out_ready = 1'b0;
    logic [2:0] dbg_state_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         valid_cycles;

    typedef struct {
        logic [7:0] len;
        logic [7:0] b [16];
        logic [7:0] csum;
        int         busy_cycles;
    } vec_t;

    vec_t vecs [6];

    packet_tx dut (
        .clk(clk), .rst(rst), .tx_packet_wr(tx_packet_wr),
        .tx_payload_len(tx_payload_len),
        .tx_buf0(buf_arr[0]),   .tx_buf1(buf_arr[1]),   .tx_buf2(buf_arr[2]),
        .tx_buf3(buf_arr[3]),   .tx_buf4(buf_arr[4]),   .tx_buf5(buf_arr[5]),
        .tx_buf6(buf_arr[6]),   .tx_buf7(buf_arr[7]),   .tx_buf8(buf_arr[8]),
        .tx_buf9(buf_arr[9]),   .tx_buf10(buf_arr[10]), .tx_buf11(buf_arr[11]),
        .tx_buf12(buf_arr[12]), .tx_buf13(buf_arr[13]), .tx_buf14(buf_arr[14]),
        .tx_buf15(buf_arr[15]),
        .tx_busy(tx_busy), .tx_overrun(tx_overrun), .out_byte(out_byte),
        .out_valid(out_valid), .out_ready(out_ready), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checkers ----------------
    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- drivers ----------------
    // Drive a one-cycle request at a falling edge; returns at the falling edge
    // after the capture edge. Payload inputs are scrambled afterwards so any
    // late sampling of tx_buf* shows up as wrong data.
    task automatic send_req(input logic [7:0] len, input logic [7:0] b [16]);
        tx_payload_len = len;
        buf_arr        = b;
        tx_packet_wr   = 1'b1;
        step();
        tx_packet_wr   = 1'b0;
        tx_payload_len = 8'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++) buf_arr[i] = 8'($urandom_range(0, 255));
    endtask

    // Collect transferred bytes until out_valid drops, checking stall stability.
    task automatic collect(input bit rnd_ready, input int budget);
        logic [7:0] prev_b;
        bit         prev_stall;
        bit         seen;
        prev_b = 8'h00;
        prev_stall = 1'b0;
        seen = 1'b0;
        got_q.delete();
        valid_cycles = 0;
        for (int c = 0; c < budget; c++) begin
            if (prev_stall) begin
                check8("stall_valid", {7'd0, out_valid}, 8'd1);
                check8("stall_byte", out_byte, prev_b);
            end
            check8("busy_eq_valid", {7'd0, tx_busy}, {7'd0, out_valid});
            if (!out_valid) begin
                check8("idle_byte_zero", out_byte, 8'h00);
                if (seen) begin
                    out_ready = 1'b0;
                    return;
                end
            end else begin
                seen = 1'b1;
                valid_cycles++;
            end
            out_ready  = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            prev_stall = out_valid && !out_ready;
            prev_b     = out_byte;
            if (out_valid && out_ready) got_q.push_back(out_byte);
            step();
        end
        checks++;
        errors++;
        $display("FAIL collect_timeout budget=%0d bytes_seen=%0d", budget, got_q.size());
        out_ready = 1'b0;
    endtask

    // ---------------- reference model ----------------
    task automatic model_frame(input logic [7:0] len, input logic [7:0] b [16]);
        int sum;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(len);
        sum = int'(len);
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back(b[i]);
            sum += int'(b[i]);
        end
        exp_q.push_back(8'(sum % 256));
    endtask

    task automatic compare_frame(input string name);
        int n;
        check_int({name, "_size"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check8($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        logic [7:0] b [16];
        logic [7:0] len;

        for (int i = 0; i < 16; i++) buf_arr[i] = 8'h00;

        // Directed table: inputs plus independently known expected checksum.
        foreach (vecs[k]) begin
            vecs[k].len = 8'd0;
            vecs[k].csum = 8'h00;
            vecs[k].busy_cycles = 3;
            for (int i = 0; i < 16; i++) vecs[k].b[i] = 8'h00;
        end
        vecs[0].len = 8'd0;  vecs[0].csum = 8'h00; vecs[0].busy_cycles = 3;
        vecs[1].len = 8'd1;  vecs[1].b[0] = 8'h81; vecs[1].csum = 8'h82; vecs[1].busy_cycles = 4;
        vecs[2].len = 8'd3;  vecs[2].b[0] = 8'h81; vecs[2].b[1] = 8'hBA; vecs[2].b[2] = 8'hCE;
        vecs[2].csum = 8'h0C; vecs[2].busy_cycles = 6;
        vecs[3].len = 8'd2;  vecs[3].b[0] = 8'h01; vecs[3].b[1] = 8'h02; vecs[3].csum = 8'h05;
        vecs[3].busy_cycles = 5;
        vecs[4].len = 8'd16; for (int i = 0; i < 16; i++) vecs[4].b[i] = 8'hFF;
        vecs[4].csum = 8'h00; vecs[4].busy_cycles = 19;
        vecs[5].len = 8'd16; for (int i = 0; i < 16; i++) vecs[5].b[i] = 8'(i + 1);
        vecs[5].csum = 8'h98; vecs[5].busy_cycles = 19;

        // Reset phase: outputs quiet, request during reset ignored.
        tx_packet_wr = 1'b1;
        tx_payload_len = 8'd1;
        repeat (3) step();
        check8("rst_valid", {7'd0, out_valid}, 8'd0);
        check8("rst_busy", {7'd0, tx_busy}, 8'd0);
        check8("rst_byte", out_byte, 8'h00);
        check8("rst_state", {5'd0, dbg_state_o}, {5'd0, ST_IDLE});
        tx_packet_wr = 1'b0;
        rst = 1'b1;
        step();
        check8("rst_wr_ignored_overrun", {7'd0, tx_overrun}, 8'd0);
        check8("rst_wr_ignored_busy", {7'd0, tx_busy}, 8'd0);

        // Table-driven frames with out_ready held high.
        foreach (vecs[k]) begin
            send_req(vecs[k].len, vecs[k].b);
            check8($sformatf("vec%0d_busy_rise", k), {7'd0, tx_busy}, 8'd1);
            check8($sformatf("vec%0d_no_overrun", k), {7'd0, tx_overrun}, 8'd0);
            collect(1'b0, 40);
            exp_q.delete();
            exp_q.push_back(8'hA5);
            exp_q.push_back(vecs[k].len);
            for (int i = 0; i < int'(vecs[k].len); i++) exp_q.push_back(vecs[k].b[i]);
            exp_q.push_back(vecs[k].csum);
            compare_frame($sformatf("vec%0d", k));
            check_int($sformatf("vec%0d_busy_cycles", k), valid_cycles, vecs[k].busy_cycles);
        end

        // Backpressure on the LEN byte.
        for (int i = 0; i < 16; i++) b[i] = 8'h00;
        b[0] = 8'h85;
        send_req(8'd1, b);
        check8("bp_sync", out_byte, 8'hA5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check8($sformatf("bp_len_hold%0d", c), out_byte, 8'h01);
            check8($sformatf("bp_valid_hold%0d", c), {7'd0, out_valid}, 8'd1);
            step();
        end
        collect(1'b0, 20);
        exp_q.delete();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h85);
        exp_q.push_back(8'h86);
        compare_frame("bp_tail");

        // Second request mid-frame: overrun pulse, first frame intact.
        for (int i = 0; i < 16; i++) b[i] = 8'h00;
        b[0] = 8'h11;
        b[1] = 8'h22;
        send_req(8'd2, b);
        b[0] = 8'hFF;
        send_req(8'd1, b);
        check8("ovr_pulse", {7'd0, tx_overrun}, 8'd1);
        step();
        check8("ovr_pulse_end", {7'd0, tx_overrun}, 8'd0);
        collect(1'b0, 20);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h35);
        compare_frame("ovr_frame");

        // Oversize request from IDLE.
        send_req(8'd17, b);
        check8("big_overrun", {7'd0, tx_overrun}, 8'd1);
        check8("big_busy", {7'd0, tx_busy}, 8'd0);
        out_ready = 1'b1;
        step();
        check8("big_overrun_end", {7'd0, tx_overrun}, 8'd0);
        check8("big_no_output", {7'd0, out_valid}, 8'd0);
        out_ready = 1'b0;

        // Reset during DATA, with a request presented in the reset cycle.
        for (int i = 0; i < 16; i++) b[i] = 8'(8'h40 + i);
        send_req(8'd4, b);
        out_ready = 1'b1;
        step();
        step();
        check8("rst_mid_in_data", {5'd0, dbg_state_o}, {5'd0, ST_DATA});
        step();
        rst = 1'b0;
        tx_packet_wr = 1'b1;
        tx_payload_len = 8'd1;
        step();
        rst = 1'b1;
        tx_packet_wr = 1'b0;
        check8("rst_mid_valid", {7'd0, out_valid}, 8'd0);
        check8("rst_mid_busy", {7'd0, tx_busy}, 8'd0);
        check8("rst_mid_byte", out_byte, 8'h00);
        step();
        check8("rst_mid_still_idle", {7'd0, out_valid}, 8'd0);
        check8("rst_mid_no_overrun", {7'd0, tx_overrun}, 8'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) b[i] = 8'h00;
        b[0] = 8'h80;
        send_req(8'd1, b);
        collect(1'b0, 20);
        model_frame(8'd1, b);
        compare_frame("post_rst");

        // Randomized frames, random backpressure, back-to-back requests.
        for (int n = 0; n < 40; n++) begin
            len = 8'($urandom_range(0, 16));
            for (int i = 0; i < 16; i++) b[i] = 8'($urandom_range(0, 255));
            send_req(len, b);
            check8($sformatf("rnd%0d_busy", n), {7'd0, tx_busy}, 8'd1);
            collect(1'b1, 300);
            model_frame(len, b);
            compare_frame($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
